// File: rtl/tpu_dma_seq.sv
// DMA sequencer feeding the TPU matrix-multiply core.
// Loads A (8 words), B (8 words) and C (16 words) from host memory into the
// TPU window, issues MatMul, waits a fixed time, then copies the 16-word
// result back to host memory.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// RD_REQ   | host read request for word k of the current phase
// RD_WAIT  | waiting for the read response
// TPU_WR   | one-cycle TPU write of the captured word
// MM_START | one-cycle MatMul command write
// MM_WAIT  | fixed wait for the TPU to finish
// C_RD     | drive TPU read address for result word k
// C_CAP    | capture TPU read data into the host write request
// WR_REQ   | host write request for result word k
// DONE     | one-cycle completion pulse
module tpu_dma_seq #(
    parameter int DIM         = 8,
    parameter int HADDRW      = 32,
    parameter int TADDRW      = 16,
    parameter int DATAW       = 64,
    parameter int MATMUL_WAIT = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [HADDRW-1:0] a_base,
    input  logic [HADDRW-1:0] b_base,
    input  logic [HADDRW-1:0] c_base,
    input  logic [HADDRW-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [HADDRW-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [DATAW-1:0]  rd_rsp_data,
    output logic              wr_req_valid,
    input  logic              wr_req_ready,
    output logic [HADDRW-1:0] wr_req_addr,
    output logic [DATAW-1:0]  wr_req_data,
    output logic              tpu_r_w,
    output logic [TADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0]  tpu_dataIn,
    input  logic [DATAW-1:0]  tpu_dataOut
);

    localparam int         WAITW     = $clog2(MATMUL_WAIT + 1);
    localparam logic [3:0] K_AB_LAST = 4'(DIM - 1);
    localparam logic [3:0] K_C_LAST  = 4'(2 * DIM - 1);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, TPU_WR, MM_START, MM_WAIT, C_RD, C_CAP, WR_REQ, DONE
    } state_t;

    typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [3:0]         k_q, k_d;
    logic [WAITW-1:0]   wait_q, wait_d;
    logic [HADDRW-1:0]  a_q, b_q, c_q, o_q;
    logic [HADDRW-1:0]  host_base;
    logic [TADDRW-1:0]  tpu_base;

    logic               busy_d, done_d, rd_req_valid_d, wr_req_valid_d, tpu_r_w_d;
    logic [HADDRW-1:0]  rd_req_addr_d, wr_req_addr_d;
    logic [DATAW-1:0]   wr_req_data_d, tpu_dataIn_d;
    logic [TADDRW-1:0]  tpu_addr_d;

    // Word offsets are k*8; host sums wrap modulo 2^HADDRW by width truncation.
    function automatic logic [HADDRW-1:0] host_off(input logic [3:0] k);
        return HADDRW'({k, 3'b000});
    endfunction

    function automatic logic [TADDRW-1:0] tpu_off(input logic [3:0] k);
        return TADDRW'({k, 3'b000});
    endfunction

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= PH_A;
            k_q          <= '0;
            wait_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
            tpu_r_w      <= 1'b0;
            tpu_addr     <= '0;
            tpu_dataIn   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            busy         <= busy_d;
            done         <= done_d;
            rd_req_valid <= rd_req_valid_d;
            rd_req_addr  <= rd_req_addr_d;
            wr_req_valid <= wr_req_valid_d;
            wr_req_addr  <= wr_req_addr_d;
            wr_req_data  <= wr_req_data_d;
            tpu_r_w      <= tpu_r_w_d;
            tpu_addr     <= tpu_addr_d;
            tpu_dataIn   <= tpu_dataIn_d;
        end
    end

    // Base addresses are latched only when a command is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            o_q <= '0;
        end else if (state_q == IDLE && start) begin
            a_q <= a_base;
            b_q <= b_base;
            c_q <= c_base;
            o_q <= out_base;
        end
    end

    // Next state, phase, word counter and MatMul wait down-counter
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_REQ;
                    phase_d = PH_A;
                    k_d     = '0;
                end
            end
            RD_REQ:  if (rd_req_ready) state_d = RD_WAIT;
            RD_WAIT: if (rd_rsp_valid) state_d = TPU_WR;
            TPU_WR: begin
                if (phase_q == PH_C) begin
                    if (k_q == K_C_LAST) begin
                        state_d = MM_START;
                    end else begin
                        state_d = RD_REQ;
                        k_d     = k_q + 4'd1;
                    end
                end else if (k_q == K_AB_LAST) begin
                    state_d = RD_REQ;
                    phase_d = (phase_q == PH_A) ? PH_B : PH_C;
                    k_d     = '0;
                end else begin
                    state_d = RD_REQ;
                    k_d     = k_q + 4'd1;
                end
            end
            MM_START: begin
                state_d = MM_WAIT;
                wait_d  = WAITW'(MATMUL_WAIT - 1);
            end
            MM_WAIT: begin
                if (wait_q == '0) begin
                    state_d = C_RD;
                    k_d     = '0;
                end else begin
                    wait_d = wait_q - WAITW'(1);
                end
            end
            C_RD:  state_d = C_CAP;
            C_CAP: state_d = WR_REQ;
            WR_REQ: begin
                if (wr_req_ready) begin
                    if (k_q == K_C_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = C_RD;
                        k_d     = k_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Base selection for the next request; the first A request uses the live inputs
    always_comb begin
        host_base = a_q;
        tpu_base  = TADDRW'(16'h0100);
        if (state_q == IDLE) begin
            host_base = a_base;
        end else begin
            case (phase_d)
                PH_B:    host_base = b_q;
                PH_C:    host_base = c_q;
                default: host_base = a_q;
            endcase
        end
        case (phase_d)
            PH_B:    tpu_base = TADDRW'(16'h0200);
            PH_C:    tpu_base = TADDRW'(16'h0300);
            default: tpu_base = TADDRW'(16'h0100);
        endcase
    end

    // Output values for the state being entered; the TPU bus defaults to an idle read of 0x0000
    always_comb begin
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr;
        wr_req_valid_d = 1'b0;
        wr_req_addr_d  = wr_req_addr;
        wr_req_data_d  = wr_req_data;
        tpu_r_w_d      = 1'b0;
        tpu_addr_d     = '0;
        tpu_dataIn_d   = '0;
        case (state_d)
            RD_REQ: begin
                rd_req_valid_d = 1'b1;
                rd_req_addr_d  = host_base + host_off(k_d);
            end
            TPU_WR: begin
                tpu_r_w_d    = 1'b1;
                tpu_addr_d   = tpu_base + tpu_off(k_d);
                tpu_dataIn_d = rd_rsp_data;
            end
            MM_START: begin
                tpu_r_w_d  = 1'b1;
                tpu_addr_d = TADDRW'(16'h0400);
            end
            C_RD, C_CAP: begin
                tpu_addr_d = TADDRW'(16'h0300) + tpu_off(k_d);
            end
            WR_REQ: begin
                wr_req_valid_d = 1'b1;
                if (state_q == C_CAP) begin
                    wr_req_data_d = tpu_dataOut;
                    wr_req_addr_d = o_q + host_off(k_d);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_dma_seq.sv
// Directed bench for tpu_dma_seq: host read/write slaves, a small TPU model
// that performs C += A*B on a MatMul write, and hand-derived expectations.
module tb_tpu_dma_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0, out_base = '0;
    logic        busy, done;
    logic        rd_req_valid, rd_req_ready = 1'b1;
    logic [31:0] rd_req_addr;
    logic        rd_rsp_valid = 1'b0;
    logic [63:0] rd_rsp_data = '0;
    logic        wr_req_valid, wr_req_ready = 1'b1;
    logic [31:0] wr_req_addr;
    logic [63:0] wr_req_data;
    logic        tpu_r_w;
    logic [15:0] tpu_addr;
    logic [63:0] tpu_dataIn, tpu_dataOut;

    int errors = 0;
    int checks = 0;
    bit bp = 1'b0;
    int fix_lrsp = 1;
    int stab_err = 0;
    int strobe_err = 0;
    int done_cnt = 0;

    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [63:0] wr_data_log[$];
    logic [15:0] tpu_addr_log[$];
    logic [63:0] tpu_data_log[$];
    logic [63:0] hmem[logic [31:0]];
    logic [63:0] tpu_a[8];
    logic [63:0] tpu_b[8];
    logic [63:0] tpu_c[16];

    tpu_dma_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_base(a_base), .b_base(b_base), .c_base(c_base), .out_base(out_base),
        .busy(busy), .done(done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
        .tpu_dataOut(tpu_dataOut)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A = identity, one 8-bit row per word, column j in byte j
    function automatic logic [63:0] a_row(input int i);
        return 64'h1 << (8 * i);
    endfunction

    function automatic logic [63:0] b_row(input int i);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(i + j);
        return r;
    endfunction

    // Result word k: row k/2, columns 4*(k%2)..+3, 16-bit lanes low first; value B[r][c] = r+c
    function automatic logic [63:0] exp_out(input int k);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[16*c +: 16] = 16'(k / 2 + 4 * (k % 2) + c);
        return r;
    endfunction

    function automatic void do_matmul();
        logic [15:0] acc;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = tpu_c[2*i + j/4][16*(j%4) +: 16];
                for (int x = 0; x < 8; x++)
                    acc = acc + 16'(tpu_a[i][8*x +: 8]) * 16'(tpu_b[x][8*j +: 8]);
                tpu_c[2*i + j/4][16*(j%4) +: 16] = acc;
            end
        end
    endfunction

    always_comb begin
        tpu_dataOut = 64'h0;
        if (tpu_addr[15:7] == 9'h006) tpu_dataOut = tpu_c[tpu_addr[6:3]];
    end

    // Host read slave: one outstanding read, response Lrsp cycles after accept
    initial begin : rd_slave
        bit          pend, wait_q;
        int          dly;
        logic [63:0] pdata;
        logic [31:0] waddr;
        pend = 0; wait_q = 0; dly = 0; pdata = '0; waddr = '0;
        forever begin
            @(negedge clk);
            rd_rsp_valid = 1'b0;
            if (pend) begin
                if (dly <= 1) begin
                    rd_rsp_valid = 1'b1;
                    rd_rsp_data  = pdata;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            if (rst_n && wait_q && !(rd_req_valid && rd_req_addr == waddr)) stab_err++;
            wait_q = 0;
            rd_req_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rst_n && rd_req_valid) begin
                if (rd_req_ready) begin
                    rd_log.push_back(rd_req_addr);
                    pdata = hmem.exists(rd_req_addr) ? hmem[rd_req_addr] : 64'h0;
                    pend  = 1;
                    dly   = bp ? int'($urandom_range(1, 7)) : fix_lrsp;
                end else begin
                    wait_q = 1;
                    waddr  = rd_req_addr;
                end
            end
        end
    end

    // Host write slave with optional random backpressure
    initial begin : wr_slave
        bit          wait_q;
        logic [31:0] wa;
        logic [63:0] wd;
        wait_q = 0; wa = '0; wd = '0;
        forever begin
            @(negedge clk);
            if (rst_n && wait_q && !(wr_req_valid && wr_req_addr == wa && wr_req_data == wd)) stab_err++;
            wait_q = 0;
            wr_req_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rst_n && wr_req_valid) begin
                if (wr_req_ready) begin
                    wr_addr_log.push_back(wr_req_addr);
                    wr_data_log.push_back(wr_req_data);
                end else begin
                    wait_q = 1;
                    wa = wr_req_addr;
                    wd = wr_req_data;
                end
            end
        end
    end

    // TPU model: logs writes, stores A/B/C, runs MatMul on 0x0400
    initial begin : tpu_model
        bit          pw;
        logic [15:0] pa;
        pw = 0; pa = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tpu_r_w) begin
                if (pw && pa == tpu_addr) strobe_err++;
                tpu_addr_log.push_back(tpu_addr);
                tpu_data_log.push_back(tpu_dataIn);
                case (tpu_addr[15:8])
                    8'h01:   tpu_a[tpu_addr[5:3]] = tpu_dataIn;
                    8'h02:   tpu_b[tpu_addr[5:3]] = tpu_dataIn;
                    8'h03:   tpu_c[tpu_addr[6:3]] = tpu_dataIn;
                    8'h04:   do_matmul();
                    default: ;
                endcase
            end
            pw = tpu_r_w;
            pa = tpu_addr;
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  64'(busy), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_rdv"},   64'(rd_req_valid), 0);
        chk({tag, "_rda"},   64'(rd_req_addr), 0);
        chk({tag, "_wrv"},   64'(wr_req_valid), 0);
        chk({tag, "_wra"},   64'(wr_req_addr), 0);
        chk({tag, "_wrd"},   wr_req_data, 0);
        chk({tag, "_rw"},    64'(tpu_r_w), 0);
        chk({tag, "_taddr"}, 64'(tpu_addr), 0);
        chk({tag, "_tdin"},  tpu_dataIn, 0);
    endtask

    task automatic prep(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        tpu_addr_log.delete(); tpu_data_log.delete();
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tpu_a[i] = '0;
            tpu_b[i] = '0;
        end
        for (int i = 0; i < 16; i++) tpu_c[i] = '0;
        hmem.delete();
        for (int i = 0; i < 8; i++) begin
            hmem[a + 32'(8 * i)] = a_row(i);
            hmem[b + 32'(8 * i)] = b_row(i);
        end
        for (int k = 0; k < 16; k++) hmem[c + 32'(8 * k)] = 64'h0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] o, input bit use_bp, input bit mid, output int ncyc);
        int idle;
        bp = use_bp;
        prep(a, b, c);
        @(negedge clk);
        a_base = a; b_base = b; c_base = c; out_base = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc = 1;
        chk("busy_on", 64'(busy), 1);
        while (!done && ncyc < 6000) begin
            if (mid && ncyc == 60) begin
                start = 1'b1;
                a_base = 32'h9000;
                out_base = 32'h9100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            ncyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 1);
        chk("busy_at_done", 64'(busy), 0);
        if (mid) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle = 0;
        repeat (20) begin
            if (busy || rd_req_valid || wr_req_valid || tpu_r_w) idle++;
            @(negedge clk);
        end
        chk("idle_after_done", 64'(idle), 0);
        bp = 1'b0;
    endtask

    task automatic check_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] o);
        logic [31:0] ea;
        logic [15:0] et;
        logic [63:0] ed;
        chk("rd_count", 64'(rd_log.size()), 32);
        for (int i = 0; i < 32 && i < rd_log.size(); i++) begin
            if (i < 8)       ea = a + 32'(8 * i);
            else if (i < 16) ea = b + 32'(8 * (i - 8));
            else             ea = c + 32'(8 * (i - 16));
            chk("rd_addr", 64'(rd_log[i]), 64'(ea));
        end
        chk("tpu_wr_count", 64'(tpu_addr_log.size()), 33);
        for (int i = 0; i < 33 && i < tpu_addr_log.size(); i++) begin
            if (i < 8) begin
                et = 16'h0100 + 16'(8 * i);        ed = a_row(i);
            end else if (i < 16) begin
                et = 16'h0200 + 16'(8 * (i - 8));  ed = b_row(i - 8);
            end else if (i < 32) begin
                et = 16'h0300 + 16'(8 * (i - 16)); ed = 64'h0;
            end else begin
                et = 16'h0400;                     ed = 64'h0;
            end
            chk("tpu_wr_addr", 64'(tpu_addr_log[i]), 64'(et));
            chk("tpu_wr_data", tpu_data_log[i], ed);
        end
        chk("wr_count", 64'(wr_addr_log.size()), 16);
        for (int k = 0; k < 16 && k < wr_addr_log.size(); k++) begin
            chk("wr_addr", 64'(wr_addr_log[k]), 64'(o + 32'(8 * k)));
            chk("wr_data", wr_data_log[k], exp_out(k));
        end
        chk("done_pulses", 64'(done_cnt), 1);
        chk("strobe_repeat", 64'(strobe_err), 0);
        chk("req_stable", 64'(stab_err), 0);
    endtask

    initial begin : main
        int n;
        int idle;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Full run with address trace
        run_cmd(32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0, n);
        chk("latency", 64'(n), 170);
        check_run(32'h1000, 32'h2000, 32'h3000, 32'h4000);
        chk("trace_first_out", wr_data_log.size() > 0 ? wr_data_log[0] : 64'hx,
            64'h0003_0002_0001_0000);

        // Backpressure and random response latency
        run_cmd(32'h8000_0000, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000, 1'b1, 1'b0, n);
        check_run(32'h8000_0000, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000);

        // Start pulses mid-run and in the DONE cycle
        run_cmd(32'h1000, 32'h2000, 32'h3000, 32'h5000, 1'b0, 1'b1, n);
        chk("latency_mid", 64'(n), 170);
        check_run(32'h1000, 32'h2000, 32'h3000, 32'h5000);

        // Reset during RD_WAIT of B word 3, then a stale response
        fix_lrsp = 5;
        prep(32'h1000, 32'h2000, 32'h3000);
        @(negedge clk);
        a_base = 32'h1000; b_base = 32'h2000; c_base = 32'h3000; out_base = 32'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rd_log.size() < 12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", 64'(rd_log.size()), 12);
        @(negedge clk);
        chk("rst_in_wait", 64'({busy, rd_req_valid, tpu_r_w}), 64'(3'b100));
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        rst_n = 1'b1;
        idle = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || rd_req_valid || wr_req_valid || tpu_r_w || done) idle++;
        end
        chk("stale_idle", 64'(idle), 0);
        chk("stale_tpu_wr", 64'(tpu_addr_log.size()), 11);
        fix_lrsp = 1;
        run_cmd(32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0, n);
        chk("latency_after_rst", 64'(n), 170);
        check_run(32'h1000, 32'h2000, 32'h3000, 32'h4000);

        // A base wraps past the top of the address space
        run_cmd(32'hFFFF_FFF8, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0, n);
        check_run(32'hFFFF_FFF8, 32'h2000, 32'h3000, 32'h4000);
        if (rd_log.size() > 1) chk("wrap_second", 64'(rd_log[1]), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
